// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared register offsets, STATUS bit indices and FSM states for uart_tx_port
package uart_tx_pkg;

   // Register offsets relative to BASE_ADDR
   localparam logic [15:0] REG_TXDATA = 16'd0;
   localparam logic [15:0] REG_STATUS = 16'd1;

   // STATUS register bit positions
   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - 8-bit wide synchronous FIFO with push/pop and full/empty flags
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, empties the FIFO
//   push       write request; ignored when full unless a pop happens on the same edge
//   push_data  byte to write
//   pop        read request; ignored when empty
//   head       byte at the read pointer (combinational)
//   full       count == DEPTH
//   empty      count == 0
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot, so a full FIFO can still take a byte.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointers are AW bits wide, so power-of-two depth wraps without compare logic.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped UART transmitter with TX FIFO and pollable STATUS register
//
// CPU writes bytes to TXDATA (BASE_ADDR); they are queued in a byte_fifo and shifted out
// 8N1, LSB first. STATUS (BASE_ADDR+1) reads {12'b0, overflow, busy, empty, full}.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; aborts any frame in progress
//   address    processor address bus
//   data_in    write data (low byte)
//   mem_read   bus read strobe
//   mem_write  bus write strobe
//   data_out   read data; STATUS on a STATUS read, 0 on a TXDATA read, high-Z otherwise
//   tx         serial line, idle high
module uart_tx_port
   import uart_tx_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR    = 16'hFF00,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  data_in,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [15:0] data_out,
   output logic        tx
);

   tx_state_t   state;
   logic [15:0] clk_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;
   logic        overflow;

   logic        wr_hit;
   logic        rd_status;
   logic        rd_txdata;
   logic        last_tick;
   logic        pop;
   logic        busy;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_head;
   logic [15:0] status;

   assign wr_hit    = mem_write && (address == BASE_ADDR + REG_TXDATA);
   assign rd_status = mem_read  && (address == BASE_ADDR + REG_STATUS);
   assign rd_txdata = mem_read  && (address == BASE_ADDR + REG_TXDATA);
   assign last_tick = (clk_cnt == 16'(CLKS_PER_BIT - 1));
   assign busy      = (state != ST_IDLE);

   // Pop from IDLE, or on the final cycle of STOP so frames run back-to-back.
   assign pop = !fifo_empty &&
                ((state == ST_IDLE) || ((state == ST_STOP) && last_tick));

   always_comb begin
      status = '0;
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_BUSY]  = busy;
      status[STAT_OVF]   = overflow;
   end

   assign data_out = rd_status ? status :
                     rd_txdata ? 16'h0000 : 16'bz;

   byte_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_hit),
      .push_data (data_in),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A drop on the same edge as a STATUS read must remain visible to the next read.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (wr_hit && fifo_full && !pop) begin
         overflow <= 1'b1;
      end else if (rd_status) begin
         overflow <= 1'b0;
      end
   end

   // tx is registered and updated on the edge that enters each bit-time.
   // shift_reg is held intact for the frame; bits are selected by bit_idx.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         tx        <= 1'b1;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               clk_cnt <= '0;
               tx      <= 1'b1;
               if (!fifo_empty) begin
                  shift_reg <= fifo_head;
                  state     <= ST_START;
                  tx        <= 1'b0;
               end
            end
            ST_START: begin
               if (last_tick) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= ST_DATA;
                  tx      <= shift_reg[0];
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (last_tick) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= ST_PARITY;
                     tx    <= ^shift_reg;
`else
                     state <= ST_STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift_reg[bit_idx + 3'd1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            ST_PARITY: begin
               if (last_tick) begin
                  clk_cnt <= '0;
                  state   <= ST_STOP;
                  tx      <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (last_tick) begin
                  clk_cnt <= '0;
                  if (!fifo_empty) begin
                     shift_reg <= fifo_head;
                     state     <= ST_START;
                     tx        <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - scoreboard testbench for uart_tx_port with a serial-line monitor
module tb_uart_tx_port;

   localparam int          C     = 4;
   localparam int          DEPTH = 4;
   localparam logic [15:0] BASE  = 16'hFF00;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [7:0]  data_in = 8'h00;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   wire  [15:0] data_out;
   wire         tx;

   always #5 clk = ~clk;

   uart_tx_port #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .data_in   (data_in),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .data_out  (data_out),
      .tx        (tx)
   );

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] data;
      int         start;
   } exp_t;

   logic [7:0] m_fifo [$];
   exp_t       exp_q [$];
   bit         m_ovf  = 0;
   bit         m_busy = 0;
   int         m_left = 0;
   int         cyc    = 0;
   bit         m_pop, m_full, m_wr, m_rd, m_set;
   exp_t       m_e;

   function automatic logic [15:0] model_status();
      return {12'h000, m_ovf, m_busy, (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         m_fifo.delete();
         exp_q.delete();
         m_ovf  = 0;
         m_busy = 0;
         m_left = 0;
      end else begin
         m_full = (m_fifo.size() == DEPTH);
         m_pop  = (m_fifo.size() > 0) && (!m_busy || m_left == 1);
         m_wr   = mem_write && (address == BASE);
         m_rd   = mem_read && (address == BASE + 16'd1);
         m_set  = 0;
         if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) m_busy = 0;
         end
         if (m_pop) begin
            m_e.data  = m_fifo.pop_front();
            m_e.start = cyc;
            exp_q.push_back(m_e);
            m_busy = 1;
            m_left = FRAME;
         end
         if (m_wr) begin
            if (!m_full || m_pop) m_fifo.push_back(data_in);
            else m_set = 1;
         end
         if (m_set) m_ovf = 1;
         else if (m_rd) m_ovf = 0;
      end
   end

   // ---------------- serial monitor ----------------
   bit         mon_active = 0;
   int         mon_start  = 0;
   int         mon_off, mon_idx;
   logic [7:0] rx;
   exp_t       mon_e;

   always @(negedge clk) begin
      if (reset) begin
         mon_active = 0;
      end else if (!mon_active) begin
         if (tx == 1'b0) begin
            mon_active = 1;
            mon_start  = cyc;
            rx         = 8'h00;
         end
      end else begin
         mon_off = cyc - mon_start;
         if (mon_off % C == C / 2) begin
            mon_idx = mon_off / C;
            if (mon_idx == 0) check("start_bit", {15'h0, tx}, 16'h0000);
            else if (mon_idx <= 8) rx[mon_idx-1] = tx;
`ifdef UART_TX_PARITY_EN
            if (mon_idx == 9) check("parity_bit", {15'h0, tx}, {15'h0, ^rx});
`endif
            if (mon_idx == NBITS - 1) begin
               check("stop_bit", {15'h0, tx}, 16'h0001);
               vectors++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_frame: got byte %h expected no frame", rx);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("frame_data", {8'h00, rx}, {8'h00, mon_e.data});
                  if (mon_start != mon_e.start) begin
                     errors++;
                     $display("FAIL frame_start: got cycle %0d expected cycle %0d", mon_start, mon_e.start);
                  end
               end
               mon_active = 0;
            end
         end
      end
   end

   // ---------------- bus tasks (called at a falling edge, return at one) ----------------
   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      address   = a;
      data_in   = d;
      mem_write = 1'b1;
      @(negedge clk);
      mem_write = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [15:0] a);
      address  = a;
      mem_read = 1'b1;
      #1;
      if (a == BASE + 16'd1) check(name, data_out, model_status());
      else if (a == BASE) check(name, data_out, 16'h0000);
      else begin
         vectors++;
         if (!(data_out === 16'hzzzz || data_out === 16'h0000)) begin
            errors++;
            $display("FAIL %s: got %h expected zzzz", name, data_out);
         end
      end
      @(negedge clk);
      mem_read = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((m_fifo.size() > 0 || m_busy || exp_q.size() > 0 || mon_active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending frames expected 0", exp_q.size());
      end
   endtask

   logic [15:0] ra;
   int          op;
   bit          stayed_high;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_tx", {15'h0, tx}, 16'h0001);
      address  = BASE + 16'd1;
      mem_read = 1'b1;
      #1 check("reset_status", data_out, 16'h0002);
      @(negedge clk);
      mem_read = 1'b0;

      // single frame latency and shape
      wr(BASE, 8'hA5);
      check("latency_edge1", {15'h0, tx}, 16'h0001);
      @(negedge clk);
      check("latency_edge2", {15'h0, tx}, 16'h0000);
      wait_drain(FRAME * 3);

`ifdef UART_TX_PARITY_EN
      wr(BASE, 8'h07);
      wr(BASE, 8'h03);
      wait_drain(FRAME * 4);
`endif

      // five back-to-back writes fill the FIFO with no overflow
      for (int i = 0; i < 5; i++) wr(BASE, 8'($urandom));
      address  = BASE + 16'd1;
      mem_read = 1'b1;
      #1 check("five_full_status", data_out, 16'h0005);
      @(negedge clk);
      mem_read = 1'b0;
      wait_drain(FRAME * 8);

      // six back-to-back writes: last one dropped
      for (int i = 0; i < 6; i++) wr(BASE, 8'($urandom));
      address  = BASE + 16'd1;
      mem_read = 1'b1;
      #1 check("overflow_set", data_out, 16'h000D);
      @(negedge clk);
      #1 check("overflow_cleared", data_out, 16'h0005);
      @(negedge clk);
      mem_read = 1'b0;
      wait_drain(FRAME * 8);

      // decode
      rd_check("status_idle", BASE + 16'd1);
      rd_check("read_txdata", BASE);
      rd_check("read_unmapped", 16'h1234);
      wr(BASE + 16'd1, 8'h55);
      rd_check("write_status_ignored", BASE + 16'd1);

      // reset in the middle of the data bits
      wr(BASE, 8'h3C);
      repeat (C * 3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_tx", {15'h0, tx}, 16'h0001);
      address  = BASE + 16'd1;
      mem_read = 1'b1;
      #1 check("abort_status", data_out, 16'h0002);
      @(negedge clk);
      mem_read = 1'b0;
      stayed_high = 1;
      repeat (FRAME + 10) begin
         if (tx !== 1'b1) stayed_high = 0;
         @(negedge clk);
      end
      check("abort_quiet", {15'h0, stayed_high}, 16'h0001);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 9);
         if (op < 5) wr(BASE, 8'($urandom));
         else if (op < 7) rd_check("rand_status", BASE + 16'd1);
         else if (op < 9) repeat ($urandom_range(1, C * 12)) @(negedge clk);
         else begin
            ra = 16'($urandom_range(0, 32'hFEFF));
            if ($urandom_range(0, 1) == 1) rd_check("rand_unmapped", ra);
            else wr(ra, 8'($urandom));
         end
      end
      wait_drain(FRAME * (DEPTH + 3));
      rd_check("final_status", BASE + 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
